id_branch_seg: RTL and testbench

ID_BRANCH_SEG -- requirements
Module: id_branch_seg

---
 rtl/id_branch_seg.sv | 121 ++++++++++++
 tb/tb_id_branch_seg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_branch_seg.sv
// ID-stage branch/jump resolver: latches fetched instructions, resolves J/JAL/JR/BEQ/BNE,
// issues a one-cycle redirect to fetch and squashes the wrong-path slots that follow it.
module id_branch_seg #(
   parameter int unsigned FLUSH_SLOTS = 2,
   parameter logic [31:0] NOP_IR      = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] NPC,
   input  logic [31:0] IR,
   input  logic        stall,
   input  logic [31:0] rsData,
   input  logic [31:0] rtData,
   output logic [4:0]  rsAddr,
   output logic [4:0]  rtAddr,
   output logic [31:0] ID_NPC,
   output logic [31:0] ID_IR,
   output logic        ID_valid,
   output logic        cond,
   output logic [31:0] condNPC,
   output logic        linkWe,
   output logic [31:0] linkData
);

   // state  | meaning
   // RUN    | normal decode; a valid taken branch in ID redirects fetch
   // SQUASH | replacing the next cnt fetched slots with NOP_IR, no redirects
   typedef enum logic {RUN, SQUASH} state_t;

   localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_SLOTS);

   state_t      state, state_nxt;
   logic [2:0]  cnt, cnt_nxt;
   logic        redirect;
   logic [5:0]  op, funct;
   logic        is_j, is_jal, is_beq, is_bne, is_jr, taken;
   logic [31:0] br_off, target;

   assign rsAddr = ID_IR[25:21];
   assign rtAddr = ID_IR[20:16];
   assign op     = ID_IR[31:26];
   assign funct  = ID_IR[5:0];

   assign is_j   = (op == 6'h02);
   assign is_jal = (op == 6'h03);
   assign is_beq = (op == 6'h04);
   assign is_bne = (op == 6'h05);
   assign is_jr  = (op == 6'h00) && (funct == 6'h08);

   assign taken = is_j || is_jal || is_jr ||
                  (is_beq && (rsData == rtData)) ||
                  (is_bne && (rsData != rtData));

   assign br_off = {{14{ID_IR[15]}}, ID_IR[15:0], 2'b00};

   always_comb begin
      target = ID_NPC + br_off;
      if (is_j || is_jal)
         target = {ID_NPC[31:28], ID_IR[25:0], 2'b00};
      else if (is_jr)
         target = rsData;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      redirect  = 1'b0;
      if (!stall) begin
         case (state)
            RUN: begin
               if (ID_valid && taken) begin
                  state_nxt = SQUASH;
                  cnt_nxt   = FLUSH_CNT;
                  redirect  = 1'b1;
               end
            end
            SQUASH: begin
               cnt_nxt = cnt - 3'd1;
               if (cnt == 3'd1)
                  state_nxt = RUN;
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         cnt      <= 3'd0;
         ID_NPC   <= 32'h0;
         ID_IR    <= NOP_IR;
         ID_valid <= 1'b0;
         cond     <= 1'b0;
         condNPC  <= 32'h0;
         linkWe   <= 1'b0;
         linkData <= 32'h0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         cond   <= redirect;
         linkWe <= redirect && is_jal;
         if (redirect)
            condNPC <= target;
         if (redirect && is_jal)
            linkData <= ID_NPC + 32'd4;
         if (!stall) begin
            ID_NPC <= NPC;
            // the slot latched on the redirect edge itself is kept; squashing starts next edge
            if (state == SQUASH) begin
               ID_IR    <= NOP_IR;
               ID_valid <= 1'b0;
            end else begin
               ID_IR    <= IR;
               ID_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_id_branch_seg.sv
// Bench for id_branch_seg: directed literal scenarios plus randomized traffic
// compared every cycle against a slot-counting behavioural model.
module tb_id_branch_seg;

   localparam int unsigned FLUSH       = 2;
   localparam logic [31:0] NOP         = 32'h00000000;
   localparam logic [31:0] FILLER      = 32'h20010001;

   logic        clk, rst, stall;
   logic [31:0] NPC, IR, rsData, rtData;
   logic [4:0]  rsAddr, rtAddr;
   logic [31:0] ID_NPC, ID_IR, condNPC, linkData;
   logic        ID_valid, cond, linkWe;

   int tests = 0;
   int fails = 0;

   id_branch_seg #(.FLUSH_SLOTS(FLUSH), .NOP_IR(NOP)) dut (
      .clk(clk), .rst(rst), .NPC(NPC), .IR(IR), .stall(stall),
      .rsData(rsData), .rtData(rtData), .rsAddr(rsAddr), .rtAddr(rtAddr),
      .ID_NPC(ID_NPC), .ID_IR(ID_IR), .ID_valid(ID_valid), .cond(cond),
      .condNPC(condNPC), .linkWe(linkWe), .linkData(linkData)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // behavioural model: pending squash slots counted directly
   logic [31:0] m_npc, m_ir, m_cnpc, m_ldata;
   logic        m_valid, m_cond, m_lwe;
   int          m_left;

   function automatic void resolve(input logic [31:0] ir, npc, rs, rt,
                                   output logic tk, output logic lk, output logic [31:0] tgt);
      int off;
      tk = 0; lk = 0; tgt = 0;
      off = int'($signed(ir[15:0])) * 4;
      case (ir[31:26])
         6'h02: begin tk = 1; tgt = {npc[31:28], ir[25:0], 2'b00}; end
         6'h03: begin tk = 1; lk = 1; tgt = {npc[31:28], ir[25:0], 2'b00}; end
         6'h04: begin tk = (rs == rt); tgt = npc + 32'(off); end
         6'h05: begin tk = (rs != rt); tgt = npc + 32'(off); end
         6'h00: if (ir[5:0] == 6'h08) begin tk = 1; tgt = rs; end
         default: ;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      logic tk, lk;
      logic [31:0] tgt;
      if (rst) begin
         m_npc = 0; m_ir = NOP; m_valid = 0; m_left = 0;
         m_cond = 0; m_cnpc = 0; m_lwe = 0; m_ldata = 0;
      end else if (stall) begin
         m_cond = 0; m_lwe = 0;
      end else begin
         tk = 0; lk = 0; tgt = 0;
         if (m_left == 0 && m_valid)
            resolve(m_ir, m_npc, rsData, rtData, tk, lk, tgt);
         m_cond = tk;
         m_lwe  = tk && lk;
         if (tk) m_cnpc = tgt;
         if (tk && lk) m_ldata = m_npc + 32'd4;
         if (m_left > 0) begin
            m_ir = NOP; m_valid = 0; m_left--;
         end else begin
            m_ir = IR; m_valid = 1;
            if (tk) m_left = FLUSH;
         end
         m_npc = NPC;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("m_ID_NPC",   ID_NPC,   m_npc);
      chk("m_ID_IR",    ID_IR,    m_ir);
      chk("m_ID_valid", 32'(ID_valid), 32'(m_valid));
      chk("m_cond",     32'(cond),     32'(m_cond));
      chk("m_condNPC",  condNPC,  m_cnpc);
      chk("m_linkWe",   32'(linkWe),   32'(m_lwe));
      chk("m_linkData", linkData, m_ldata);
      chk("m_rsAddr",   32'(rsAddr),   32'(m_ir[25:21]));
      chk("m_rtAddr",   32'(rtAddr),   32'(m_ir[20:16]));
   end

   task automatic drive(input logic [31:0] npc_v, ir_v, input logic st,
                        input logic [31:0] rs_v, rt_v);
      NPC = npc_v; IR = ir_v; stall = st; rsData = rs_v; rtData = rt_v;
      @(posedge clk);
      #2;
   endtask

   task automatic flush();
      for (int i = 0; i < 8; i++) drive(32'h1000 + 32'(4*i), FILLER, 0, 0, 1);
   endtask

   function automatic logic [31:0] rand_ir();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 6))
         0: r[31:26] = 6'h02;
         1: r[31:26] = 6'h03;
         2: r[31:26] = 6'h04;
         3: r[31:26] = 6'h05;
         4: begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      logic [31:0] rv;
      rst = 1; stall = 0; NPC = 0; IR = 0; rsData = 0; rtData = 0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_ID_IR",    ID_IR, NOP);
      chk("rst_ID_valid", 32'(ID_valid), 0);
      chk("rst_cond",     32'(cond), 0);
      chk("rst_condNPC",  condNPC, 0);
      rst = 0;

      // BEQ taken, then squash of the following slots
      flush();
      drive(32'h104, 32'h10220003, 0, 0, 1);
      drive(32'h108, FILLER, 0, 5, 5);
      chk("beq_cond", 32'(cond), 1);
      chk("beq_condNPC", condNPC, 32'h110);
      drive(32'h10C, FILLER, 0, 0, 1);
      chk("beq_sq1_ir", ID_IR, NOP);
      chk("beq_sq1_valid", 32'(ID_valid), 0);
      chk("beq_cond_pulse", 32'(cond), 0);
      drive(32'h110, FILLER, 0, 0, 1);
      chk("beq_sq2_ir", ID_IR, NOP);
      chk("beq_sq2_valid", 32'(ID_valid), 0);
      drive(32'h114, FILLER, 0, 0, 1);
      chk("beq_resume_valid", 32'(ID_valid), 1);

      // BNE backwards taken, then not taken
      flush();
      drive(32'h200, 32'h1422FFFF, 0, 0, 0);
      drive(32'h204, FILLER, 0, 1, 2);
      chk("bne_cond", 32'(cond), 1);
      chk("bne_condNPC", condNPC, 32'h1FC);
      flush();
      drive(32'h200, 32'h1422FFFF, 0, 0, 0);
      drive(32'h204, FILLER, 0, 7, 7);
      chk("bne_nt_cond", 32'(cond), 0);
      drive(32'h208, FILLER, 0, 0, 1);
      chk("bne_nt_valid", 32'(ID_valid), 1);

      // JAL
      flush();
      drive(32'h30000008, 32'h0C000040, 0, 0, 1);
      drive(32'h3000000C, FILLER, 0, 0, 1);
      chk("jal_cond", 32'(cond), 1);
      chk("jal_condNPC", condNPC, 32'h30000100);
      chk("jal_linkWe", 32'(linkWe), 1);
      chk("jal_linkData", linkData, 32'h3000000C);

      // JR
      flush();
      drive(32'h400, 32'h03E00008, 0, 0, 1);
      chk("jr_rsAddr", 32'(rsAddr), 31);
      drive(32'h404, FILLER, 0, 32'h0000ABC0, 0);
      chk("jr_cond", 32'(cond), 1);
      chk("jr_condNPC", condNPC, 32'h0000ABC0);

      // stall holds a taken BEQ
      flush();
      drive(32'h104, 32'h10220003, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         drive(32'h900, FILLER, 1, 5, 5);
         chk("stall_cond", 32'(cond), 0);
         chk("stall_ir", ID_IR, 32'h10220003);
         chk("stall_npc", ID_NPC, 32'h104);
      end
      drive(32'h108, FILLER, 0, 5, 5);
      chk("stall_rel_cond", 32'(cond), 1);
      chk("stall_rel_condNPC", condNPC, 32'h110);

      // reset in the second squash slot
      flush();
      drive(32'h104, 32'h10220003, 0, 0, 1);
      drive(32'h108, FILLER, 0, 5, 5);
      drive(32'h10C, FILLER, 0, 0, 1);
      rst = 1;
      #1;
      chk("rst_sq_ID_NPC", ID_NPC, 0);
      chk("rst_sq_ID_IR", ID_IR, NOP);
      chk("rst_sq_valid", 32'(ID_valid), 0);
      chk("rst_sq_cond", 32'(cond), 0);
      chk("rst_sq_condNPC", condNPC, 0);
      chk("rst_sq_linkWe", 32'(linkWe), 0);
      chk("rst_sq_linkData", linkData, 0);
      rst = 0;
      drive(32'h30000008, 32'h0C000040, 0, 0, 1);
      chk("rst_sq_next_valid", 32'(ID_valid), 1);
      drive(32'h3000000C, FILLER, 0, 0, 1);
      chk("rst_sq_redirect", 32'(cond), 1);
      chk("rst_sq_redirNPC", condNPC, 32'h30000100);

      // randomized traffic, checked by the per-cycle compare process
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            rst = 1;
            #1;
            rst = 0;
         end
         rv = $urandom;
         drive($urandom, rand_ir(), ($urandom_range(0, 4) == 0), rv,
               ($urandom_range(0, 1) == 1) ? rv : $urandom);
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
